// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: opcodes, control-word layout,
// and the canned control words produced by the decoder.
package ctrl_pkg;

    localparam int CW_W = 21;

    // Primary opcode lives in INSTR[31:26]
    localparam logic [5:0] OP_LDW  = 6'h12;
    localparam logic [5:0] OP_STW  = 6'h13;
    localparam logic [5:0] OP_ADD  = 6'h18;
    localparam logic [5:0] OP_SUB  = 6'h19;
    localparam logic [5:0] OP_ADDI = 6'h1C;
    localparam logic [5:0] OP_BR   = 6'h20;

    // Destination-register source selection
    typedef enum logic [1:0] {
        SRD_RD   = 2'b00,
        SRD_RS1  = 2'b01,
        SRD_RS2  = 2'b10,
        SRD_NONE = 2'b11
    } srd_sel_e;

    // Control word, MSB first; total width equals CW_W
    typedef struct packed {
        srd_sel_e   srd;
        logic [1:0] psw_le_re;
        logic       b;
        logic [2:0] soh_op;
        logic [3:0] alu_op;
        logic [3:0] ram_ctrl;
        logic       l;
        logic       rf_le;
        logic [1:0] id_sr;
        logic       ub;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP = '0;

    localparam ctrl_word_t CW_ADD = '{srd: SRD_RD, psw_le_re: 2'b00, b: 1'b0,
        soh_op: 3'b000, alu_op: 4'b0000, ram_ctrl: 4'b0000, l: 1'b0, rf_le: 1'b1,
        id_sr: 2'b11, ub: 1'b0};

    localparam ctrl_word_t CW_SUB = '{srd: SRD_RD, psw_le_re: 2'b11, b: 1'b0,
        soh_op: 3'b000, alu_op: 4'b0001, ram_ctrl: 4'b0000, l: 1'b0, rf_le: 1'b1,
        id_sr: 2'b11, ub: 1'b0};

    localparam ctrl_word_t CW_ADDI = '{srd: SRD_RS2, psw_le_re: 2'b00, b: 1'b0,
        soh_op: 3'b001, alu_op: 4'b0000, ram_ctrl: 4'b0000, l: 1'b0, rf_le: 1'b1,
        id_sr: 2'b01, ub: 1'b0};

    localparam ctrl_word_t CW_LDW = '{srd: SRD_RD, psw_le_re: 2'b00, b: 1'b0,
        soh_op: 3'b001, alu_op: 4'b0000, ram_ctrl: 4'b1010, l: 1'b1, rf_le: 1'b1,
        id_sr: 2'b01, ub: 1'b0};

    localparam ctrl_word_t CW_STW = '{srd: SRD_RD, psw_le_re: 2'b00, b: 1'b0,
        soh_op: 3'b001, alu_op: 4'b0000, ram_ctrl: 4'b1110, l: 1'b0, rf_le: 1'b0,
        id_sr: 2'b11, ub: 1'b0};

    localparam ctrl_word_t CW_BR = '{srd: SRD_NONE, psw_le_re: 2'b00, b: 1'b1,
        soh_op: 3'b010, alu_op: 4'b0000, ram_ctrl: 4'b0000, l: 1'b0, rf_le: 1'b0,
        id_sr: 2'b00, ub: 1'b1};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps the ID-stage instruction onto a
// control word and the destination register it will write.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output ctrl_word_t            ctrl_word,
    output logic [REG_ADDR_W-1:0] dest
);

    // Opcode lookup; invalid, all-zero and unknown instructions become NOP
    always_comb begin
        ctrl_word = CW_NOP;
        if (instr_valid && (instr != 32'd0)) begin
            case (instr[31:26])
                OP_ADD:  ctrl_word = CW_ADD;
                OP_SUB:  ctrl_word = CW_SUB;
                OP_ADDI: ctrl_word = CW_ADDI;
                OP_LDW:  ctrl_word = CW_LDW;
                OP_STW:  ctrl_word = CW_STW;
                OP_BR:   ctrl_word = CW_BR;
                default: ctrl_word = CW_NOP;
            endcase
        end
    end

    // Destination field chosen by SRD; a NOP carries no destination at all
    always_comb begin
        dest = '0;
        if (ctrl_word != CW_NOP) begin
            case (ctrl_word.srd)
                SRD_RD:   dest = REG_ADDR_W'(instr[4:0]);
                SRD_RS1:  dest = REG_ADDR_W'(instr[25:21]);
                SRD_RS2:  dest = REG_ADDR_W'(instr[20:16]);
                default:  dest = '0;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: decodes the ID instruction, carries control words through
// NUM_STAGES registered stages, and handles load-use bubbles, branch flushes
// and external freezes, counting every bubble it inserts.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [31:0]                      INSTR,
    input  logic                             INSTR_VALID,
    input  logic                             STALL_IN,
    input  logic                             BRANCH_TAKEN,
    output logic [CW_W-1:0]                  CTRL_ID,
    output logic [NUM_STAGES*CW_W-1:0]       CTRL_STAGE,
    output logic [NUM_STAGES*REG_ADDR_W-1:0] DEST_STAGE,
    output logic                             HAZARD_STALL,
    output logic                             PC_LE,
    output logic                             IFID_LE,
    output logic                             FLUSH_ID,
    output logic [CNT_W-1:0]                 BUBBLE_CNT
);

    ctrl_word_t            id_word;
    logic [REG_ADDR_W-1:0] id_dest;
    ctrl_word_t            stage0_word;
    logic [REG_ADDR_W-1:0] stage0_dest;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  load_use;
    logic                  load_nop;
    logic                  bubble;
    logic [CNT_W-1:0]      bubble_cnt_q;

    ctrl_decode #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .instr       (INSTR),
        .instr_valid (INSTR_VALID),
        .ctrl_word   (id_word),
        .dest        (id_dest)
    );

    assign CTRL_ID     = id_word;
    assign stage0_word = load_nop ? CW_NOP : id_word;
    assign stage0_dest = load_nop ? '0 : id_dest;

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            ctrl_word_t            ctrl_r;
            logic [REG_ADDR_W-1:0] dest_r;

            if (k == 0) begin : g_first
                // EX stage takes the decoded word, or a bubble, unless frozen
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ctrl_r <= CW_NOP;
                        dest_r <= '0;
                    end else if (!STALL_IN) begin
                        ctrl_r <= stage0_word;
                        dest_r <= stage0_dest;
                    end
                end
            end else begin : g_rest
                // Later stages shift down from the previous stage unless frozen
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ctrl_r <= CW_NOP;
                        dest_r <= '0;
                    end else if (!STALL_IN) begin
                        ctrl_r <= ctrl_word_t'(CTRL_STAGE[(k-1)*CW_W +: CW_W]);
                        dest_r <= DEST_STAGE[(k-1)*REG_ADDR_W +: REG_ADDR_W];
                    end
                end
            end

            assign CTRL_STAGE[k*CW_W +: CW_W]             = ctrl_r;
            assign DEST_STAGE[k*REG_ADDR_W +: REG_ADDR_W] = dest_r;
        end
    endgenerate

    assign ex_dest  = DEST_STAGE[REG_ADDR_W-1:0];
    assign load_use = g_stage[0].ctrl_r.l && g_stage[0].ctrl_r.rf_le && (ex_dest != '0) &&
                      ((id_word.id_sr[0] && (ex_dest == REG_ADDR_W'(INSTR[25:21]))) ||
                       (id_word.id_sr[1] && (ex_dest == REG_ADDR_W'(INSTR[20:16]))));

    // Flow control, prioritised freeze > branch flush > load-use bubble;
    // while in reset everything sits at its free-running defaults
    always_comb begin
        HAZARD_STALL = 1'b0;
        FLUSH_ID     = 1'b0;
        PC_LE        = 1'b1;
        IFID_LE      = 1'b1;
        load_nop     = 1'b0;
        if (rst_n) begin
            if (STALL_IN) begin
                PC_LE   = 1'b0;
                IFID_LE = 1'b0;
            end else if (BRANCH_TAKEN) begin
                FLUSH_ID = 1'b1;
                load_nop = 1'b1;
            end else if (load_use) begin
                HAZARD_STALL = 1'b1;
                PC_LE        = 1'b0;
                IFID_LE      = 1'b0;
                load_nop     = 1'b1;
            end
        end
    end

    assign bubble = HAZARD_STALL | FLUSH_ID;

    // Saturating count of inserted bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign BUBBLE_CNT = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: expected stage contents are queued
// when each cycle is driven and compared once the clock edge has taken effect.
module tb_ctrl_pipeline;

    localparam int NS  = 3;
    localparam int RW  = 5;
    localparam int CNW = 16;
    localparam int CWW = 21;

    localparam logic [20:0] W_ADD  = 21'h00000E;
    localparam logic [20:0] W_SUB  = 21'h06020E;
    localparam logic [20:0] W_ADDI = 21'h10200A;
    localparam logic [20:0] W_LDW  = 21'h00215A;
    localparam logic [20:0] W_STW  = 21'h0021C6;
    localparam logic [20:0] W_BR   = 21'h194001;

    typedef struct packed {
        logic        hold;
        logic [20:0] w;
        logic [4:0]  d;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       INSTR;
    logic              INSTR_VALID;
    logic              STALL_IN;
    logic              BRANCH_TAKEN;
    logic [CWW-1:0]    CTRL_ID;
    logic [NS*CWW-1:0] CTRL_STAGE;
    logic [NS*RW-1:0]  DEST_STAGE;
    logic              HAZARD_STALL;
    logic              PC_LE;
    logic              IFID_LE;
    logic              FLUSH_ID;
    logic [CNW-1:0]    BUBBLE_CNT;

    int          checks = 0;
    int          errors = 0;
    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [20:0] hw[NS];
    logic [4:0]  hd[NS];
    logic [15:0] exp_cnt;

    ctrl_pipeline #(
        .NUM_STAGES (NS),
        .REG_ADDR_W (RW),
        .CNT_W      (CNW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .INSTR        (INSTR),
        .INSTR_VALID  (INSTR_VALID),
        .STALL_IN     (STALL_IN),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .CTRL_ID      (CTRL_ID),
        .CTRL_STAGE   (CTRL_STAGE),
        .DEST_STAGE   (DEST_STAGE),
        .HAZARD_STALL (HAZARD_STALL),
        .PC_LE        (PC_LE),
        .IFID_LE      (IFID_LE),
        .FLUSH_ID     (FLUSH_ID),
        .BUBBLE_CNT   (BUBBLE_CNT)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] exp_word(input logic [31:0] instr, input logic valid);
        if (!valid || instr == 32'd0) return 21'd0;
        case (instr[31:26])
            6'h18:   return W_ADD;
            6'h19:   return W_SUB;
            6'h1C:   return W_ADDI;
            6'h12:   return W_LDW;
            6'h13:   return W_STW;
            6'h20:   return W_BR;
            default: return 21'd0;
        endcase
    endfunction

    function automatic logic [4:0] exp_dest(input logic [31:0] instr, input logic [20:0] w);
        if (w == 21'd0) return 5'd0;
        case (w[20:19])
            2'b00:   return instr[4:0];
            2'b01:   return instr[25:21];
            2'b10:   return instr[20:16];
            default: return 5'd0;
        endcase
    endfunction

    // Scoreboard: pop one expectation per clock, shift the expected stage
    // history (unless frozen) and compare every stage
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (!mon_e.hold) begin
                for (int k = NS - 1; k > 0; k--) begin
                    hw[k] = hw[k-1];
                    hd[k] = hd[k-1];
                end
                hw[0] = mon_e.w;
                hd[0] = mon_e.d;
            end
            for (int k = 0; k < NS; k++) begin
                checks++;
                if (CTRL_STAGE[k*CWW +: CWW] !== hw[k] || DEST_STAGE[k*RW +: RW] !== hd[k]) begin
                    errors++;
                    $display("[TB] FAIL stage%0d: got ctrl=%h dest=%0d, expected ctrl=%h dest=%0d",
                             k, CTRL_STAGE[k*CWW +: CWW], DEST_STAGE[k*RW +: RW], hw[k], hd[k]);
                end
            end
        end
    end

    task automatic clear_model();
        sb_q.delete();
        for (int k = 0; k < NS; k++) begin
            hw[k] = '0;
            hd[k] = '0;
        end
        exp_cnt = '0;
    endtask

    // Drive one cycle from a negedge, sample flow-control outputs, queue the
    // expected stage-0 result, and return on the following negedge
    task automatic drive_cycle(input logic [31:0] instr, input logic valid, input logic stall,
                               input logic branch, input logic bubble_exp,
                               output logic haz, output logic flush,
                               output logic pcle, output logic ifle);
        sb_t e;
        INSTR        = instr;
        INSTR_VALID  = valid;
        STALL_IN     = stall;
        BRANCH_TAKEN = branch;
        #1;
        haz   = HAZARD_STALL;
        flush = FLUSH_ID;
        pcle  = PC_LE;
        ifle  = IFID_LE;
        e.hold = stall;
        e.w    = (stall || bubble_exp) ? 21'd0 : exp_word(instr, valid);
        e.d    = (stall || bubble_exp) ? 5'd0 : exp_dest(instr, e.w);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        INSTR        = 32'h6000_0005;
        INSTR_VALID  = 1'b1;
        STALL_IN     = 1'b1;
        BRANCH_TAKEN = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (CTRL_STAGE !== '0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h, expected 0", CTRL_STAGE); end
        checks++; if (DEST_STAGE !== '0) begin errors++; $display("[TB] FAIL reset_dest: got %h, expected 0", DEST_STAGE); end
        checks++; if (BUBBLE_CNT !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d, expected 0", BUBBLE_CNT); end
        checks++; if (HAZARD_STALL !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b, expected 0", HAZARD_STALL); end
        checks++; if (FLUSH_ID !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %b, expected 0", FLUSH_ID); end
        checks++; if (PC_LE !== 1'b1 || IFID_LE !== 1'b1) begin errors++; $display("[TB] FAIL reset_le: got pc=%b ifid=%b, expected 1 1", PC_LE, IFID_LE); end
        checks++; if (CTRL_ID !== W_ADD) begin errors++; $display("[TB] FAIL reset_ctrl_id_add: got %h, expected %h", CTRL_ID, W_ADD); end
        INSTR = 32'h6400_0005;
        #1;
        checks++; if (CTRL_ID !== W_SUB) begin errors++; $display("[TB] FAIL reset_ctrl_id_sub: got %h, expected %h", CTRL_ID, W_SUB); end
        @(negedge clk);
        STALL_IN     = 1'b0;
        BRANCH_TAKEN = 1'b0;
        INSTR_VALID  = 1'b0;
        INSTR        = 32'd0;
        rst_n        = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ins[9]  = '{32'h6000_0005, 32'h6400_0005, 32'h7003_0005, 32'h4800_0003,
                                 32'h4C00_0003, 32'h8000_0000, 32'h0000_0000, 32'h6000_0005,
                                 32'hFC00_0001};
        logic        vld[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [20:0] expw[9] = '{W_ADD, W_SUB, W_ADDI, W_LDW, W_STW, W_BR, 21'd0, 21'd0, 21'd0};
        STALL_IN     = 1'b1;
        BRANCH_TAKEN = 1'b0;
        for (int i = 0; i < 9; i++) begin
            INSTR       = ins[i];
            INSTR_VALID = vld[i];
            #1;
            checks++;
            if (CTRL_ID !== expw[i]) begin
                errors++;
                $display("[TB] FAIL decode[%0d] instr=%h valid=%b: got %h, expected %h", i, ins[i], vld[i], CTRL_ID, expw[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic h, f, p, i;
        drive_cycle(32'h6000_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (p !== 1'b1 || i !== 1'b1 || h !== 1'b0) begin errors++; $display("[TB] FAIL normal_flow: got pc=%b ifid=%b haz=%b, expected 1 1 0", p, i, h); end
        checks++; if (CTRL_STAGE[12:9] !== 4'b0000 || CTRL_STAGE[3] !== 1'b1 || DEST_STAGE[4:0] !== 5'd5) begin
            errors++; $display("[TB] FAIL add_stage0: got alu=%b rf_le=%b dest=%0d, expected 0000 1 5", CTRL_STAGE[12:9], CTRL_STAGE[3], DEST_STAGE[4:0]);
        end
        drive_cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (CTRL_STAGE[2*CWW +: CWW] !== W_ADD || DEST_STAGE[2*RW +: RW] !== 5'd5) begin
            errors++; $display("[TB] FAIL add_stage2: got ctrl=%h dest=%0d, expected %h 5", CTRL_STAGE[2*CWW +: CWW], DEST_STAGE[2*RW +: RW], W_ADD);
        end
    endtask

    task automatic test_hazard();
        logic h, f, p, i;
        drive_cycle(32'h4800_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b0, 1'b1, h, f, p, i);
        exp_cnt++;
        checks++; if (h !== 1'b1 || p !== 1'b0 || i !== 1'b0 || f !== 1'b0) begin
            errors++; $display("[TB] FAIL hazard_rs1: got haz=%b pc=%b ifid=%b flush=%b, expected 1 0 0 0", h, p, i, f);
        end
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL hazard_cnt: got %0d, expected %0d", BUBBLE_CNT, exp_cnt); end
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (h !== 1'b0 || p !== 1'b1) begin errors++; $display("[TB] FAIL hazard_once: got haz=%b pc=%b, expected 0 1", h, p); end
        // rs2 match also stalls
        drive_cycle(32'h4800_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6003_0005, 1'b1, 1'b0, 1'b0, 1'b1, h, f, p, i);
        exp_cnt++;
        checks++; if (h !== 1'b1) begin errors++; $display("[TB] FAIL hazard_rs2: got %b, expected 1", h); end
        drive_cycle(32'h6003_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        // load into r0 never stalls
        drive_cycle(32'h4800_0000, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6000_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL hazard_r0: got %b, expected 0", h); end
        // ADDI matches rs2 field but does not read it
        drive_cycle(32'h4800_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h7003_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL hazard_unread: got %b, expected 0", h); end
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL hazard_cnt2: got %0d, expected %0d", BUBBLE_CNT, exp_cnt); end
    endtask

    task automatic test_stall();
        logic h, f, p, i;
        drive_cycle(32'h4800_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6060_0005, 1'b1, 1'b1, 1'b0, 1'b0, h, f, p, i);
        checks++; if (h !== 1'b0 || p !== 1'b0 || i !== 1'b0 || f !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_flags: got haz=%b pc=%b ifid=%b flush=%b, expected 0 0 0 0", h, p, i, f);
        end
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL stall_cnt: got %0d, expected %0d", BUBBLE_CNT, exp_cnt); end
        drive_cycle(32'h6060_0005, 1'b1, 1'b1, 1'b1, 1'b0, h, f, p, i);
        checks++; if (f !== 1'b0 || h !== 1'b0) begin errors++; $display("[TB] FAIL stall_over_branch: got flush=%b haz=%b, expected 0 0", f, h); end
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b0, 1'b1, h, f, p, i);
        exp_cnt++;
        checks++; if (h !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_hazard: got %b, expected 1", h); end
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL stall_cnt2: got %0d, expected %0d", BUBBLE_CNT, exp_cnt); end
    endtask

    task automatic test_branch();
        logic h, f, p, i;
        drive_cycle(32'h6400_0007, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6000_0005, 1'b1, 1'b0, 1'b1, 1'b1, h, f, p, i);
        exp_cnt++;
        checks++; if (f !== 1'b1 || h !== 1'b0 || p !== 1'b1 || i !== 1'b1) begin
            errors++; $display("[TB] FAIL branch_flags: got flush=%b haz=%b pc=%b ifid=%b, expected 1 0 1 1", f, h, p, i);
        end
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL branch_cnt: got %0d, expected %0d", BUBBLE_CNT, exp_cnt); end
        // branch wins over a pending load-use hazard
        drive_cycle(32'h4800_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b1, 1'b1, h, f, p, i);
        exp_cnt++;
        checks++; if (h !== 1'b0 || f !== 1'b1 || p !== 1'b1) begin errors++; $display("[TB] FAIL branch_over_hazard: got haz=%b flush=%b pc=%b, expected 0 1 1", h, f, p); end
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL branch_cnt2: got %0d, expected %0d", BUBBLE_CNT, exp_cnt); end
    endtask

    task automatic test_saturation();
        logic h, f, p, i;
        force dut.bubble_cnt_q = 16'hFFFF;
        drive_cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, h, f, p, i);
        release dut.bubble_cnt_q;
        exp_cnt = 16'hFFFF;
        drive_cycle(32'h4800_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL sat_preload: got %h, expected %h", BUBBLE_CNT, exp_cnt); end
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b0, 1'b1, h, f, p, i);
        checks++; if (h !== 1'b1) begin errors++; $display("[TB] FAIL sat_hazard: got %b, expected 1", h); end
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL sat_hold: got %h, expected %h", BUBBLE_CNT, exp_cnt); end
        drive_cycle(32'h6060_0005, 1'b1, 1'b0, 1'b1, 1'b1, h, f, p, i);
        checks++; if (BUBBLE_CNT !== exp_cnt) begin errors++; $display("[TB] FAIL sat_hold_branch: got %h, expected %h", BUBBLE_CNT, exp_cnt); end
    endtask

    task automatic test_async_reset();
        logic h, f, p, i;
        drive_cycle(32'h6000_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h6400_0007, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h7009_0000, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        INSTR       = 32'h6000_0005;
        INSTR_VALID = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (CTRL_STAGE !== '0 || DEST_STAGE !== '0) begin
            errors++; $display("[TB] FAIL async_reset_stages: got ctrl=%h dest=%h, expected 0 0", CTRL_STAGE, DEST_STAGE);
        end
        checks++; if (BUBBLE_CNT !== 16'd0 || HAZARD_STALL !== 1'b0 || PC_LE !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset_misc: got cnt=%h haz=%b pc=%b, expected 0 0 1", BUBBLE_CNT, HAZARD_STALL, PC_LE);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(32'h6000_0005, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h4C00_0003, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, h, f, p, i);
        drive_cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, h, f, p, i);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_latency();
        test_hazard();
        test_stall();
        test_branch();
        test_saturation();
        test_async_reset();
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
